// File: rtl/zero_cross_hyst.sv
// Zero-crossing detector with hysteresis band and dwell qualification.
// Watches a signed sample stream, emits one-cycle pulses on qualified
// neg->pos / pos->neg crossings and measures the sample count between
// successive positive crossings with a saturating counter.
module zero_cross_hyst #(
    parameter int W     = 16,
    parameter int DWELL = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                en,
    input  logic signed [W-1:0] X,
    input  logic [W-2:0]        hyst,
    output logic                outP,
    output logic                outN,
    output logic                sign,
    output logic                sign_vld,
    output logic [CNT_W-1:0]    period,
    output logic                period_vld,
    output logic                period_sat
);

    localparam int                DW_W    = (DWELL < 2) ? 1 : $clog2(DWELL + 1);
    localparam logic [DW_W-1:0]   DWELL_V = DW_W'(DWELL);
    localparam logic [DW_W-1:0]   DW_ONE  = DW_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic [1:0] {INIT, POS, NEG} state_t;

    state_t            state, state_nxt;
    logic [DW_W-1:0]   dwell, dwell_nxt, dwell_inc;
    logic              side, side_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              first_seen, first_seen_nxt;
    logic [CNT_W-1:0]  period_nxt;
    logic              period_sat_nxt;
    logic              outP_nxt, outN_nxt, period_vld_nxt;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Comparisons are done one bit wider so that -hyst is always representable.
    logic signed [W:0] x_ext, hyst_pos, hyst_neg;
    logic              above, below;

    assign x_ext     = {X[W-1], X};
    assign hyst_pos  = $signed({2'b00, hyst});
    assign hyst_neg  = -hyst_pos;
    assign above     = (x_ext > hyst_pos);
    assign below     = (x_ext < hyst_neg);
    assign dwell_inc = dwell + 1'b1;

    assign sign     = (state == POS);
    assign sign_vld = (state != INIT);

    // Next-state, dwell qualification, crossing pulses and period capture.
    always_comb begin
        state_nxt      = state;
        dwell_nxt      = dwell;
        side_nxt       = side;
        cnt_nxt        = cnt;
        first_seen_nxt = first_seen;
        period_nxt     = period;
        period_sat_nxt = period_sat;
        outP_nxt       = 1'b0;
        outN_nxt       = 1'b0;
        period_vld_nxt = 1'b0;

        if (en) begin
            cnt_nxt = sat_inc(cnt);

            case (state)
                INIT: begin
                    if (above || below) begin
                        // A side change before qualification restarts the run.
                        if ((dwell != '0) && (side == above)) dwell_nxt = dwell_inc;
                        else                                   dwell_nxt = DW_ONE;
                        side_nxt = above;
                    end else begin
                        dwell_nxt = '0;
                    end
                end
                POS:     dwell_nxt = below ? dwell_inc : '0;
                NEG:     dwell_nxt = above ? dwell_inc : '0;
                default: dwell_nxt = '0;
            endcase

            if (dwell_nxt == DWELL_V) begin
                dwell_nxt = '0;
                case (state)
                    INIT: state_nxt = above ? POS : NEG;
                    POS: begin
                        state_nxt = NEG;
                        outN_nxt  = 1'b1;
                    end
                    NEG: begin
                        state_nxt = POS;
                        outP_nxt  = 1'b1;
                        if (first_seen) begin
                            period_nxt     = sat_inc(cnt);
                            period_sat_nxt = (cnt == CNT_MAX);
                            period_vld_nxt = 1'b1;
                        end
                        cnt_nxt        = '0;
                        first_seen_nxt = 1'b1;
                    end
                    default: state_nxt = INIT;
                endcase
            end
        end
    end

    // Polarity state register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= INIT;
        else        state <= state_nxt;
    end

    // Dwell, period counter and registered outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            dwell      <= '0;
            side       <= 1'b0;
            cnt        <= '0;
            first_seen <= 1'b0;
            period     <= '0;
            period_sat <= 1'b0;
            period_vld <= 1'b0;
            outP       <= 1'b0;
            outN       <= 1'b0;
        end else begin
            dwell      <= dwell_nxt;
            side       <= side_nxt;
            cnt        <= cnt_nxt;
            first_seen <= first_seen_nxt;
            period     <= period_nxt;
            period_sat <= period_sat_nxt;
            period_vld <= period_vld_nxt;
            outP       <= outP_nxt;
            outN       <= outN_nxt;
        end
    end

endmodule

// File: tb/tb_zero_cross_hyst.sv
// Directed bench for zero_cross_hyst: vector table plus square-wave,
// counter-saturation, async reset and single-sample-dwell sequences.
module tb_zero_cross_hyst;

    logic               clk;
    logic               clr_n;
    logic               en;
    logic signed [15:0] X;
    logic [14:0]        hyst;

    logic        m_outP, m_outN, m_sign, m_sign_vld, m_period_vld, m_period_sat;
    logic [15:0] m_period;
    logic        c_outP, c_outN, c_sign, c_sign_vld, c_period_vld, c_period_sat;
    logic [3:0]  c_period;
    logic        d_outP, d_outN, d_sign, d_sign_vld, d_period_vld, d_period_sat;
    logic [15:0] d_period;

    int checks = 0;
    int errors = 0;

    zero_cross_hyst #(.W(16), .DWELL(2), .CNT_W(16)) u_main (
        .clk(clk), .clr_n(clr_n), .en(en), .X(X), .hyst(hyst),
        .outP(m_outP), .outN(m_outN), .sign(m_sign), .sign_vld(m_sign_vld),
        .period(m_period), .period_vld(m_period_vld), .period_sat(m_period_sat)
    );

    zero_cross_hyst #(.W(16), .DWELL(2), .CNT_W(4)) u_c4 (
        .clk(clk), .clr_n(clr_n), .en(en), .X(X), .hyst(hyst),
        .outP(c_outP), .outN(c_outN), .sign(c_sign), .sign_vld(c_sign_vld),
        .period(c_period), .period_vld(c_period_vld), .period_sat(c_period_sat)
    );

    zero_cross_hyst #(.W(16), .DWELL(1), .CNT_W(16)) u_d1 (
        .clk(clk), .clr_n(clr_n), .en(en), .X(X), .hyst(hyst),
        .outP(d_outP), .outN(d_outN), .sign(d_sign), .sign_vld(d_sign_vld),
        .period(d_period), .period_vld(d_period_vld), .period_sat(d_period_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                 rep;
        logic               en;
        logic signed [15:0] x;
        logic [14:0]        hyst;
        logic [4:0]         flags;   // {outP, outN, sign, sign_vld, period_vld}
        logic [15:0]        period;
    } vec_t;

    vec_t vt [24];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic e, input logic signed [15:0] x);
        en = e;
        X  = x;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    function automatic logic signed [15:0] wave(input int k, input int half);
        return ((((k - 1) / half) % 2) == 0) ? 16'sd1000 : -16'sd1000;
    endfunction

    initial begin
        logic expP, expN, expV;

        vt[0]  = '{20, 1'b1, 16'sd0,      15'd50,     5'b00000, 16'd0};
        vt[1]  = '{1,  1'b1, 16'sd1000,   15'd50,     5'b00000, 16'd0};
        vt[2]  = '{1,  1'b1, 16'sd1000,   15'd50,     5'b00110, 16'd0};
        vt[3]  = '{10, 1'b1, -16'sd40,    15'd50,     5'b00110, 16'd0};
        vt[4]  = '{1,  1'b1, -16'sd60,    15'd50,     5'b00110, 16'd0};
        vt[5]  = '{1,  1'b1, -16'sd60,    15'd50,     5'b01010, 16'd0};
        vt[6]  = '{1,  1'b1, -16'sd60,    15'd50,     5'b00010, 16'd0};
        vt[7]  = '{3,  1'b1, 16'sd0,      15'd0,      5'b00010, 16'd0};
        vt[8]  = '{1,  1'b1, 16'sd1,      15'd0,      5'b00010, 16'd0};
        vt[9]  = '{1,  1'b1, 16'sd0,      15'd0,      5'b00010, 16'd0};
        vt[10] = '{1,  1'b1, 16'sd1,      15'd0,      5'b00010, 16'd0};
        vt[11] = '{1,  1'b1, 16'sd1,      15'd0,      5'b10110, 16'd0};
        vt[12] = '{1,  1'b1, -16'sd100,   15'd50,     5'b00110, 16'd0};
        vt[13] = '{1,  1'b1, -16'sd100,   15'd50,     5'b01010, 16'd0};
        vt[14] = '{1,  1'b1, 16'sd100,    15'd50,     5'b00010, 16'd0};
        vt[15] = '{1,  1'b1, -16'sd100,   15'd50,     5'b00010, 16'd0};
        vt[16] = '{1,  1'b1, 16'sd100,    15'd50,     5'b00010, 16'd0};
        vt[17] = '{1,  1'b1, -16'sd100,   15'd50,     5'b00010, 16'd0};
        vt[18] = '{1,  1'b1, 16'sd100,    15'd50,     5'b00010, 16'd0};
        vt[19] = '{3,  1'b0, -16'sd1000,  15'd50,     5'b00010, 16'd0};
        vt[20] = '{1,  1'b1, 16'sd100,    15'd50,     5'b10111, 16'd8};
        vt[21] = '{3,  1'b1, 16'sh7fff,   15'h7fff,   5'b00110, 16'd8};
        vt[22] = '{1,  1'b1, 16'sh8000,   15'h7fff,   5'b00110, 16'd8};
        vt[23] = '{1,  1'b1, 16'sh8000,   15'h7fff,   5'b01010, 16'd8};

        clr_n = 1'b1;
        en    = 1'b0;
        X     = '0;
        hyst  = 15'd50;
        #1 clr_n = 1'b0;
        #2;
        chk("reset_flags", 32'({m_outP, m_outN, m_sign, m_sign_vld, m_period_vld, m_period_sat}), 32'd0);
        chk("reset_period", 32'(m_period), 32'd0);
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;

        // Table: startup, hysteresis band, hyst=0, glitches, en gaps, extreme values
        for (int i = 0; i < 24; i++) begin
            hyst = vt[i].hyst;
            for (int r = 0; r < vt[i].rep; r++) begin
                step(vt[i].en, vt[i].x);
                chk($sformatf("vec%0d_flags", i),
                    32'({m_outP, m_outN, m_sign, m_sign_vld, m_period_vld}), 32'(vt[i].flags));
                chk($sformatf("vec%0d_period", i), 32'(m_period), 32'(vt[i].period));
            end
        end

        // Square wave +-1000, 5 samples per half, with en gaps mid-dwell later on
        hyst = 15'd50;
        do_reset();
        for (int k = 1; k <= 60; k++) begin
            if (k == 42 || k == 47) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, -wave(k, 5));
                    chk("gap_pulses", 32'({m_outP, m_outN, m_period_vld}), 32'd0);
                end
            end
            step(1'b1, wave(k, 5));
            expP = (k >= 12) && (((k - 12) % 10) == 0);
            expN = (k >= 7)  && (((k - 7) % 10) == 0);
            expV = (k >= 22) && (((k - 12) % 10) == 0);
            chk($sformatf("sq%0d_pulses", k), 32'({m_outP, m_outN, m_period_vld}), 32'({expP, expN, expV}));
            if (expV) chk($sformatf("sq%0d_period", k), 32'(m_period), 32'd10);
        end

        // Crossings 20 samples apart: the 4-bit counter saturates
        do_reset();
        for (int k = 1; k <= 51; k++) begin
            step(1'b1, wave(k, 10));
            chk($sformatf("c4_%0d_outP", k), 32'(c_outP), 32'((k == 22) || (k == 42)));
            if (k == 22) chk("c4_first_pvld", 32'({c_period_vld, m_period_vld}), 32'd0);
            if (k == 42) begin
                chk("c4_sat_flags", 32'({c_period_vld, c_period_sat}), 32'b11);
                chk("c4_sat_period", 32'(c_period), 32'd15);
                chk("main_period20", 32'({m_period_vld, m_period_sat}), 32'b10);
                chk("main_period20_val", 32'(m_period), 32'd20);
            end
        end

        // Async reset mid-dwell clears outputs without waiting for a clock edge
        #2 clr_n = 1'b0;
        #1;
        chk("async_rst_main", 32'({m_outP, m_outN, m_sign, m_sign_vld, m_period_vld, m_period_sat}), 32'd0);
        chk("async_rst_main_period", 32'(m_period), 32'd0);
        chk("async_rst_c4", 32'({c_outP, c_outN, c_sign, c_sign_vld, c_period_vld, c_period_sat}), 32'd0);
        chk("async_rst_c4_period", 32'(c_period), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;

        // DWELL=1: one qualifying sample is enough
        step(1'b1, 16'sd1000);
        chk("d1_init_pos", 32'({d_outP, d_outN, d_sign, d_sign_vld}), 32'b0011);
        chk("main_still_init", 32'(m_sign_vld), 32'd0);
        step(1'b1, -16'sd1000);
        chk("d1_outN", 32'({d_outP, d_outN, d_sign, d_sign_vld}), 32'b0101);
        step(1'b1, 16'sd1000);
        chk("d1_outP", 32'({d_outP, d_outN, d_sign, d_period_vld}), 32'b1010);
        step(1'b1, 16'sd1000);
        chk("d1_outP_drop", 32'({d_outP, d_outN, d_sign}), 32'b001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
